// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O unit: register addresses,
// control bit indices and status field layout.
package io_pkg;

    localparam int IO_DATA      = 'h3F;
    localparam int IO_CTRL      = 'h3E;

    localparam int CTRL_POP     = 0;
    localparam int CTRL_CLR_OVF = 1;

    localparam int ST_CNT_LSB   = 0;

    // Status word: count in the LSBs, overflow flag immediately above it.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ovf_pos(input int depth);
        return cnt_w(depth);
    endfunction

endpackage

// File: rtl/io_ctrl_if.sv
// Processor/memory bus seen by the I/O unit.
interface io_ctrl_if #(
    parameter int NBITS = 8
);
    logic [NBITS-3:0] memAddress;
    logic [NBITS-1:0] memWriteData;
    logic             memMemWrite;
    logic [NBITS-1:0] memQ;
    logic [NBITS-1:0] memReadData;
    logic             memWren;

    modport master (
        output memAddress, memWriteData, memMemWrite, memQ,
        input  memReadData, memWren
    );

    modport slave (
        input  memAddress, memWriteData, memMemWrite, memQ,
        output memReadData, memWren
    );
endinterface

// File: rtl/io_ctrl_fifo.sv
// Small change-event FIFO. A pop on empty is ignored; on a full FIFO a
// simultaneous pop frees the slot the push then uses.
module io_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: nothing is readable until count says so.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped I/O: output register, synchronized input change queue with
// interrupt, and the read-data mux in front of memory.
module io_ctrl
    import io_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    io_ctrl_if.slave         bus,
    input  logic [NBITS-1:0] entrada,
    output logic [NBITS-1:0] saida,
    output logic             interrupt
);

    localparam int AW = NBITS - 2;
    localparam int CW = cnt_w(DEPTH);

    logic [NBITS-1:0] s1, s2, prev;
    logic [1:0]       prime_cnt;
    logic             primed, change;
    logic             ovf, ovf_set;
    logic             sel_data, sel_ctrl;
    logic             pop_req, clr_req;
    logic [NBITS-1:0] head, status;
    logic [CW-1:0]    count;
    logic             full, empty;

    assign sel_data = (bus.memAddress == AW'(IO_DATA));
    assign sel_ctrl = (bus.memAddress == AW'(IO_CTRL));
    assign bus.memWren = bus.memMemWrite & ~(sel_data | sel_ctrl);

    assign pop_req = bus.memMemWrite & sel_ctrl & bus.memWriteData[CTRL_POP];
    assign clr_req = bus.memMemWrite & sel_ctrl & bus.memWriteData[CTRL_CLR_OVF];

    assign primed  = (prime_cnt == 2'd3);
    assign change  = (s2 != prev) & primed;
    // A pop in the same cycle makes room, so only an unrelieved full drops data.
    assign ovf_set = change & full & ~pop_req;

    io_fifo #(.WIDTH(NBITS), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (change),
        .pop   (pop_req),
        .din   (s2),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign interrupt = ~empty;

    always_comb begin
        status = '0;
        status[ST_CNT_LSB +: CW]  = count;
        status[ovf_pos(DEPTH)]    = ovf;
    end

    always_comb begin
        bus.memReadData = bus.memQ;
        if (sel_data)
            bus.memReadData = empty ? '0 : head;
        else if (sel_ctrl)
            bus.memReadData = status;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            prev      <= '0;
            prime_cnt <= '0;
            ovf       <= 1'b0;
            saida     <= '0;
        end else begin
            s1 <= entrada;
            s2 <= s1;
            if (!primed)
                prime_cnt <= prime_cnt + 2'd1;
            if (!primed || change)
                prev <= s2;
            if (ovf_set)
                ovf <= 1'b1;
            else if (clr_req)
                ovf <= 1'b0;
            if (bus.memMemWrite && sel_data)
                saida <= bus.memWriteData;
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the input/interrupt behaviour.
module tb_io_ctrl;

    localparam int NBITS = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NBITS-1:0] entrada;
    logic [NBITS-1:0] saida;
    logic             interrupt;

    io_ctrl_if #(.NBITS(NBITS)) bus ();

    io_ctrl #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .bus       (bus),
        .entrada   (entrada),
        .saida     (saida),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model state
    logic [7:0] q[$];
    bit         ovf_m;
    logic [7:0] saida_m;
    logic [7:0] hist0, hist1;   // entrada sampled one / two edges ago
    logic [7:0] last;
    int         since_rst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd();
        if (bus.memAddress == 6'h3F) return (q.size() != 0) ? q[0] : 8'h00;
        if (bus.memAddress == 6'h3E) return 8'((ovf_m ? 8 : 0) + q.size());
        return bus.memQ;
    endfunction

    task automatic model_edge();
        logic [7:0] seen;
        bit ev, set, pop, clr;
        if (!rst_n) begin
            q.delete();
            ovf_m = 0; saida_m = 0; hist0 = 0; hist1 = 0; last = 0; since_rst = 0;
            return;
        end
        seen = hist1;
        ev   = (since_rst >= 3) && (seen != last);
        last = seen;
        hist1 = hist0;
        hist0 = entrada;
        if (since_rst < 3) since_rst++;
        if (bus.memMemWrite && bus.memAddress == 6'h3F) saida_m = bus.memWriteData;
        pop = bus.memMemWrite && bus.memAddress == 6'h3E && bus.memWriteData[0];
        clr = bus.memMemWrite && bus.memAddress == 6'h3E && bus.memWriteData[1];
        set = 0;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (ev) begin
            if (q.size() < DEPTH) q.push_back(seen);
            else set = 1;
        end
        if (set) ovf_m = 1;
        else if (clr) ovf_m = 0;
    endtask

    // Inputs are set at the negedge; compare, take the edge, return at next negedge.
    task automatic tick();
        #2;
        chk("rdata", bus.memReadData, model_rd());
        chk("wren", bus.memWren, bus.memMemWrite && !(bus.memAddress inside {6'h3E, 6'h3F}));
        chk("saida", saida, saida_m);
        chk("irq", interrupt, q.size() != 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rd(input logic [5:0] a);
        bus.memAddress = a; bus.memMemWrite = 1'b0;
        bus.memWriteData = 8'h00;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        bus.memAddress = a; bus.memMemWrite = 1'b1;
        bus.memWriteData = d;
    endtask

    task automatic pop_check(input logic [7:0] exp, input string tag);
        rd(6'h3F); #1;
        chk(tag, bus.memReadData, exp);
        wr(6'h3E, 8'h01); tick();
    endtask

    initial begin
        q.delete(); ovf_m = 0; saida_m = 0; hist0 = 0; hist1 = 0; last = 0; since_rst = 0;
        rst_n = 1'b0; entrada = 8'hA5; bus.memQ = 8'h9C;
        rd(6'h3E);
        @(negedge clk);

        // 1: reset with input held, no spurious event
        repeat (3) tick();
        chk("rst_saida", saida, 8'h00);
        chk("rst_irq", interrupt, 1'b0);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("prime_irq", interrupt, 1'b0);
        chk("prime_stat", bus.memReadData, 8'h00);

        // 2: output register and write gating
        wr(6'h3F, 8'h3C); #1;
        chk("io_wren", bus.memWren, 1'b0);
        tick();
        chk("saida_3c", saida, 8'h3C);
        wr(6'h10, 8'h11); #1;
        chk("mem_wren", bus.memWren, 1'b1);
        tick();
        rd(6'h10); #1;
        chk("memq_pass", bus.memReadData, 8'h9C);

        // 3: latency of one change
        entrada = 8'h55; rd(6'h3E);
        tick(); tick();
        chk("lat_lo", interrupt, 1'b0);
        tick();
        chk("lat_hi", interrupt, 1'b1);
        chk("lat_cnt", bus.memReadData, 8'h01);
        rd(6'h3F); #1;
        chk("lat_data", bus.memReadData, 8'h55);
        wr(6'h3E, 8'h01); tick();
        chk("pop_irq", interrupt, 1'b0);

        // 4: overflow on fifth change, drain, clear
        rd(6'h3E);
        for (int i = 1; i <= 5; i++) begin entrada = 8'(i); tick(); end
        repeat (3) tick();
        chk("ovf_stat", bus.memReadData, 8'h0C);
        pop_check(8'h01, "ovf_h1");
        pop_check(8'h02, "ovf_h2");
        pop_check(8'h03, "ovf_h3");
        pop_check(8'h04, "ovf_h4");
        wr(6'h3E, 8'h02); tick();
        rd(6'h3E); #1;
        chk("ovf_clr", bus.memReadData, 8'h00);

        // 5: full FIFO, change lands with a pop
        foreach (q[i]) ;
        entrada = 8'h11; tick(); entrada = 8'h22; tick();
        entrada = 8'h33; tick(); entrada = 8'h44; tick();
        tick(); tick();
        chk("full_stat", bus.memReadData, 8'h04);
        entrada = 8'h77; tick(); tick();
        wr(6'h3E, 8'h01); tick();
        rd(6'h3E); #1;
        chk("pp_stat", bus.memReadData, 8'h04);
        pop_check(8'h22, "pp_h1");
        pop_check(8'h33, "pp_h2");
        pop_check(8'h44, "pp_h3");
        pop_check(8'h77, "pp_last");

        // 6: reset discards queued events
        rd(6'h3E);
        entrada = 8'h01; tick(); entrada = 8'h02; tick();
        tick(); tick();
        chk("pre_rst", bus.memReadData, 8'h02);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_rst_stat", bus.memReadData, 8'h00);
        chk("mid_rst_irq", interrupt, 1'b0);
        wr(6'h3E, 8'h03); tick();
        rd(6'h3E); #1;
        chk("empty_pop", bus.memReadData, 8'h00);
        repeat (4) tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int sel;
            if ($urandom_range(3) == 0) entrada = 8'($urandom);
            bus.memQ = 8'($urandom);
            sel = $urandom_range(3);
            bus.memAddress = (sel == 0) ? 6'h3F : (sel == 1) ? 6'h3E : 6'($urandom);
            bus.memMemWrite = ($urandom_range(2) == 0);
            bus.memWriteData = 8'($urandom);
            if ($urandom_range(60) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
